// File: rtl/c9_bist_ctrl.sv
// Exhaustive BIST sequencer for the 4-input C9 netlist: applies vectors 0..15,
// samples G5gat after a settle delay and tallies mismatches against EXPECT.
module c9_bist_ctrl #(
    parameter int unsigned SETTLE = 1,
    parameter logic [15:0] EXPECT = 16'hFFFF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] dut_in,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] fail_count,
    output logic [3:0] first_fail_vec,
    output logic       first_fail_valid
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    logic [0:0] state_q, state_d;
    logic [3:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] dut_in_q, dut_in_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [4:0] fail_q, fail_d;
    logic [3:0] ffvec_q, ffvec_d;
    logic       ffvalid_q, ffvalid_d;
    logic       mismatch;

    assign mismatch = dut_out ^ EXPECT[vec_q];

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        dut_in_d  = dut_in_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        fail_d    = fail_q;
        ffvec_d   = ffvec_q;
        ffvalid_d = ffvalid_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d   = S_WAIT;
                    vec_d     = '0;
                    cnt_d     = SETTLE_CNT;
                    dut_in_d  = '0;
                    busy_d    = 1'b1;
                    pass_d    = 1'b0;
                    fail_d    = '0;
                    ffvec_d   = '0;
                    ffvalid_d = 1'b0;
                end
            end
            default: begin
                // Abort outranks a coinciding sample edge; partial tallies are kept.
                if (abort) begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    pass_d   = 1'b0;
                    dut_in_d = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (mismatch) begin
                        fail_d = fail_q + 5'd1;
                        if (!ffvalid_q) begin
                            ffvec_d   = vec_q;
                            ffvalid_d = 1'b1;
                        end
                    end
                    if (vec_q != 4'hF) begin
                        vec_d    = vec_q + 4'd1;
                        cnt_d    = SETTLE_CNT;
                        dut_in_d = vec_q + 4'd1;
                    end else begin
                        state_d  = S_IDLE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        pass_d   = (fail_d == '0);
                        dut_in_d = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            vec_q     <= '0;
            cnt_q     <= '0;
            dut_in_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= '0;
            ffvec_q   <= '0;
            ffvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            dut_in_q  <= dut_in_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            ffvec_q   <= ffvec_d;
            ffvalid_q <= ffvalid_d;
        end
    end

    assign dut_in           = dut_in_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign fail_count       = fail_q;
    assign first_fail_vec   = ffvec_q;
    assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_c9_bist_ctrl.sv
// Self-checking bench for c9_bist_ctrl: two instances (SETTLE=1 and SETTLE=0),
// netlist faults injected by a per-vector mask, outcomes predicted from the rules.
module tb_c9_bist_ctrl;

    localparam logic [15:0] EXP0 = 16'hFFFF;
    localparam logic [15:0] EXP1 = 16'hA5C3;

    logic             clk = 1'b0;
    logic [1:0]       rst_s   = '0;
    logic [1:0]       start_s = '0;
    logic [1:0]       abort_s = '0;
    logic [1:0][3:0]  din_s;
    logic [1:0]       dout_s;
    logic [1:0]       busy_s, done_s, pass_s, ffvalid_s;
    logic [1:0][4:0]  fc_s;
    logic [1:0][3:0]  ffvec_s;
    logic [1:0][15:0] mask_s = '0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Faulty netlist model: correct response flipped wherever the mask bit is set.
    assign dout_s[0] = EXP0[din_s[0]] ^ mask_s[0][din_s[0]];
    assign dout_s[1] = EXP1[din_s[1]] ^ mask_s[1][din_s[1]];

    c9_bist_ctrl #(.SETTLE(1), .EXPECT(EXP0)) u_dut0 (
        .clk(clk), .reset_n(rst_s[0]), .start(start_s[0]), .abort(abort_s[0]),
        .dut_in(din_s[0]), .dut_out(dout_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .pass(pass_s[0]), .fail_count(fc_s[0]), .first_fail_vec(ffvec_s[0]),
        .first_fail_valid(ffvalid_s[0])
    );

    c9_bist_ctrl #(.SETTLE(0), .EXPECT(EXP1)) u_dut1 (
        .clk(clk), .reset_n(rst_s[1]), .start(start_s[1]), .abort(abort_s[1]),
        .dut_in(din_s[1]), .dut_out(dout_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .pass(pass_s[1]), .fail_count(fc_s[1]), .first_fail_vec(ffvec_s[1]),
        .first_fail_valid(ffvalid_s[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Expected tallies after the first nsmp vectors have been sampled.
    task automatic tally(input logic [15:0] m, input int nsmp,
                         output int fc, output int first, output int fvalid);
        fc = 0; first = 0; fvalid = 0;
        for (int v = 0; v < nsmp && v < 16; v++) begin
            if (m[v]) begin
                if (fc == 0) begin first = v; fvalid = 1; end
                fc++;
            end
        end
    endtask

    task automatic check_all(input int u, input string ph, input int b, input int d,
                             input int di, input int p, input int fc, input int ff,
                             input int fv);
        check({ph, ".busy"},  int'(busy_s[u]),    b);
        check({ph, ".done"},  int'(done_s[u]),    d);
        check({ph, ".dut_in"}, int'(din_s[u]),    di);
        check({ph, ".pass"},  int'(pass_s[u]),    p);
        check({ph, ".fail_count"}, int'(fc_s[u]), fc);
        check({ph, ".ffvec"}, int'(ffvec_s[u]),   ff);
        check({ph, ".ffvalid"}, int'(ffvalid_s[u]), fv);
    endtask

    // One run on unit u with fault mask m. abort_n / restart_n / rst_n_at give the
    // cycle offset after the start edge for those events (-1 = none).
    task automatic run_seq(input int u, input logic [15:0] m, input int abort_n,
                           input int restart_n, input int rst_n_at);
        int p, fc, ff, fv, ffc, fff, ffv;
        string ph;
        p = (u == 0) ? 2 : 1;
        ph = $sformatf("u%0d_m%04h", u, m);
        mask_s[u] = m;
        tally(m, 16, ffc, fff, ffv);
        @(negedge clk); start_s[u] = 1'b1;
        @(negedge clk); start_s[u] = 1'b0;
        for (int n = 0; n <= 16 * p; n++) begin
            if (n > 0) @(negedge clk);
            start_s[u] = (n == restart_n);
            tally(m, n / p, fc, ff, fv);
            if (n < 16 * p)
                check_all(u, $sformatf("%s.run%0d", ph, n), 1, 0, n / p, 0, fc, ff, fv);
            else
                check_all(u, {ph, ".end"}, 0, 1, 0, (ffc == 0) ? 1 : 0, ffc, fff, ffv);
            if (n == abort_n) begin
                abort_s[u] = 1'b1;
                @(negedge clk); abort_s[u] = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    check_all(u, {ph, ".abort"}, 0, 0, 0, 0, fc, ff, fv);
                    @(negedge clk);
                end
                return;
            end
            if (n == rst_n_at) begin
                rst_s[u] = 1'b0;
                #1 check_all(u, {ph, ".rst"}, 0, 0, 0, 0, 0, 0, 0);
                @(negedge clk); rst_s[u] = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check_all(u, {ph, ".postrst"}, 0, 0, 0, 0, 0, 0, 0);
                end
                return;
            end
        end
        start_s[u] = 1'b0;
        @(negedge clk);
        check_all(u, {ph, ".hold"}, 0, 0, 0, (ffc == 0) ? 1 : 0, ffc, fff, ffv);
        // start+abort together in IDLE: abort wins, results retained.
        start_s[u] = 1'b1; abort_s[u] = 1'b1;
        @(negedge clk); start_s[u] = 1'b0; abort_s[u] = 1'b0;
        check_all(u, {ph, ".stab"}, 0, 0, 0, (ffc == 0) ? 1 : 0, ffc, fff, ffv);
    endtask

    initial begin
        logic [15:0] rm;
        repeat (2) @(negedge clk);
        check_all(0, "reset0", 0, 0, 0, 0, 0, 0, 0);
        check_all(1, "reset1", 0, 0, 0, 0, 0, 0, 0);
        rst_s = 2'b11;
        // abort alone in IDLE: nothing happens.
        abort_s[0] = 1'b1;
        @(negedge clk); abort_s[0] = 1'b0;
        check_all(0, "idle_abort", 0, 0, 0, 0, 0, 0, 0);

        run_seq(0, 16'h0000, -1, -1, -1);
        run_seq(0, 16'hFFFF, -1, -1, -1);
        run_seq(0, 16'h0408, -1, -1, -1);
        run_seq(0, 16'h1234, 14, -1, -1);
        run_seq(0, 16'h0000, -1, -1, -1);
        run_seq(0, 16'h0810, -1, 9, -1);
        run_seq(0, 16'h00F0, -1, -1, 11);
        run_seq(1, 16'h0000, -1, -1, -1);
        run_seq(1, 16'h8001, -1, -1, -1);
        run_seq(1, 16'h0000, 7, -1, -1);

        for (int i = 0; i < 8; i++) begin
            rm = 16'($urandom);
            if (i == 0) rm = 16'h0000;
            if (i == 1) rm = 16'h8000;
            run_seq(i % 2, rm, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
                    int'($urandom_range(1, 15)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/c9_bist_ctrl.md
# c9_bist_ctrl

Exhaustive built-in self-test sequencer for the 4-input, 1-output C9 benchmark circuit (inputs G1gat..G4gat, output G5gat). On a start pulse it drives all 16 input vectors in ascending order, waits a programmable settle time per vector, and samples the circuit output. Each sample is compared against an expected truth table, and the block accumulates a mismatch count and the first failing vector. It sits beside the netlist under test and owns its inputs during a run.

## Interface
- SETTLE, default 1: idle cycles between applying a vector and sampling it (0..15); covers the combinational path delay.
- EXPECT, default 16'hFFFF: expected truth table; bit i is the expected G5gat for vector i. The C9 function is constant 1.
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  single-cycle run request; honoured only in IDLE
- abort  input  1  terminates a run; no done pulse is issued
- dut_in  output  4  drives the netlist: dut_in[3]=G1gat, [2]=G2gat, [1]=G3gat, [0]=G4gat
- dut_out  input  1  G5gat from the netlist
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse when a run completes
- pass  output  1  high when the last completed run had zero mismatches
- fail_count  output  5  number of mismatches in the current or last run (0..16)
- first_fail_vec  output  4  vector index of the first mismatch
- first_fail_valid  output  1  high when first_fail_vec is meaningful

## Operation
- States: IDLE and WAIT. Internal registers: vec[3:0] and cnt[3:0]. dut_in equals vec while in WAIT and is 0 in IDLE.
- IDLE to WAIT: taken on start=1 and abort=0. On that edge:
  - vec<=0, cnt<=SETTLE, busy<=1.
  - fail_count<=0, first_fail_valid<=0, first_fail_vec<=0, pass<=0.
- WAIT with cnt!=0: cnt<=cnt-1.
- WAIT with cnt==0 (sample edge): mismatch = dut_out ^ EXPECT[vec].
  - On a mismatch, fail_count increments.
  - On a mismatch with first_fail_valid=0, first_fail_vec<=vec and first_fail_valid<=1.
  - If vec!=15: vec<=vec+1, cnt<=SETTLE.
  - If vec==15: state<=IDLE, busy<=0, done<=1, pass<=(updated fail_count==0), dut_in<=0.
- abort=1 in WAIT: at the next edge, state<=IDLE, busy<=0, pass<=0, dut_in<=0, and no done pulse. fail_count and first_fail_* keep their partial values.
- abort=1 in IDLE: no effect. If start and abort are both high in IDLE, abort wins and the block stays in IDLE.
- start while busy: ignored, with no restart and no side effects.
- done is high for exactly one cycle and is cleared at the following edge.
- fail_count, first_fail_*, and pass are held in IDLE until the next accepted start.
- fail_count cannot exceed 16, so the 5-bit width never wraps.

## Timing
- Reset (reset_n=0, asynchronous): state=IDLE, dut_in=0, busy=0, done=0, pass=0, fail_count=0, first_fail_vec=0, first_fail_valid=0. Reset mid-run discards the run immediately, with no done pulse.
- Start accepted at edge k: vector v is driven from edge k+v*(SETTLE+1) and sampled at edge k+(v+1)*(SETTLE+1).
- Each vector is held for SETTLE+1 cycles. dut_out is sampled at least SETTLE+1 cycles after dut_in changes.
- Final sample occurs at edge k+16*(SETTLE+1). done and updated pass are visible in the cycle after that edge; busy falls at the same edge.
- Full-run latency from the start edge to done high: 32 cycles for SETTLE=1, 16 cycles for SETTLE=0.
- A new start is accepted in the cycle done is high, since state is already IDLE.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Fault-free netlist, SETTLE=1, start pulse -> dut_in steps 0,0,1,1,...,15,15; done 32 cycles after start; pass=1; fail_count=0; first_fail_valid=0.
- dut_out forced to 0 -> fail_count=16, pass=0, first_fail_vec=0, first_fail_valid=1.
- dut_out forced to 0 only when dut_in is 4'hA or 4'h3 -> fail_count=2, first_fail_vec=4'h3, pass=0.
- abort while vec=7 -> next cycle busy=0, dut_in=0, no done, pass=0. A following start runs clean with pass=1 and fail_count=0.
- Two cases:
  - reset_n pulled low mid-run -> all outputs 0 immediately, no done.
  - start pulsed while busy -> sequence unaffected, single done.
- SETTLE=0 with fault-free netlist -> dut_in changes every cycle; done 16 cycles after start; pass=1.
